// File: rtl/sprite_blitter_pkg.sv
// Shared definitions for the sprite blitter: state encoding, screen geometry,
// transparent colour and the sprite ids used by the game's draw commands.
package sprite_blitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;

  localparam logic [2:0] DEF_TRANSPARENT = 3'b101;
  localparam int         DEF_SCREEN_W    = 160;
  localparam int         DEF_SCREEN_H    = 120;

  localparam logic [3:0] TILE_FLOOR = 4'd0;
  localparam logic [3:0] TILE_WALL  = 4'd1;
  localparam logic [3:0] TILE_CRATE = 4'd2;
  localparam logic [3:0] EXPLOSION  = 4'd3;
  localparam logic [3:0] BOMB       = 4'd4;
  localparam logic [3:0] P1         = 4'd5;
  localparam logic [3:0] P2         = 4'd6;
  localparam logic [3:0] HEART      = 4'd7;

endpackage

// File: rtl/sprite_blitter_addr_counter.sv
// Row/column raster counter with a last-pixel flag; also usable for a
// full-screen copy by widening COL_W/ROW_W.
module blit_addr_counter #(
  parameter int COL_W = 4,
  parameter int ROW_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (enable) begin
      col <= col + 1'b1;
      if (&col) row <= row + 1'b1;
    end
  end

  assign last = (&row) & (&col);

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from the sprite ROM into the frame buffer at a latched
// origin, clipping to the screen and skipping transparent pixels unless black.
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int                  SPRITE_W    = 16,
  parameter int                  SPRITE_H    = 16,
  parameter int                  SCREEN_W    = DEF_SCREEN_W,
  parameter int                  SCREEN_H    = DEF_SCREEN_H,
  parameter int                  X_W         = 8,
  parameter int                  Y_W         = 7,
  parameter int                  COLOR_W     = 3,
  parameter int                  ID_W        = 4,
  parameter logic [COLOR_W-1:0]  TRANSPARENT = DEF_TRANSPARENT,
  localparam int                 COL_W       = $clog2(SPRITE_W),
  localparam int                 ROW_W       = $clog2(SPRITE_H),
  localparam int                 ROM_AW      = ID_W + ROW_W + COL_W,
  localparam int                 BUF_AW      = $clog2(SCREEN_W * SCREEN_H)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               draw_req,
  input  logic [ID_W-1:0]    sprite_id,
  input  logic [X_W-1:0]     origin_x,
  input  logic [Y_W-1:0]     origin_y,
  input  logic               black,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [BUF_AW-1:0]  buf_addr,
  output logic [COLOR_W-1:0] buf_data,
  output logic               buf_we,
  output logic               finished,
  output logic               busy
);

  localparam logic [X_W:0] SCR_W_C = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H_C = (Y_W+1)'(SCREEN_H);

  blit_state_t state_q, state_d;
  logic latch_en, cnt_en;

  logic [ID_W-1:0] id_l;
  logic [X_W-1:0]  ox_l;
  logic [Y_W-1:0]  oy_l;
  logic            black_l;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last;

  logic [X_W:0] x_sum, x_p1;
  logic [Y_W:0] y_sum, y_p1;
  logic         in_p1, vld_p1;

  function automatic logic pixel_written(input logic force_black,
                                         input logic [COLOR_W-1:0] color);
    return force_black | (color != TRANSPARENT);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (draw_req) begin
          latch_en = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (last) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (latch_en) begin
      id_l    <= sprite_id;
      ox_l    <= origin_x;
      oy_l    <= origin_y;
      black_l <= black;
    end
  end

  blit_addr_counter #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (latch_en),
    .enable (cnt_en),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  // Stage p0: ROM address and destination coordinates (one spare bit, no wrap)
  assign rom_addr = (state_q == ST_RUN) ? {id_l, row, col} : '0;
  assign x_sum    = {1'b0, ox_l} + (X_W+1)'(col);
  assign y_sum    = {1'b0, oy_l} + (Y_W+1)'(row);

  // Stage p1: ROM data arrives alongside the registered destination
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= (state_q == ST_RUN);
  end

  always_ff @(posedge clock) begin
    x_p1  <= x_sum;
    y_p1  <= y_sum;
    in_p1 <= (x_sum < SCR_W_C) && (y_sum < SCR_H_C);
  end

  assign buf_addr = vld_p1 ? (BUF_AW'(y_p1) * BUF_AW'(SCREEN_W) + BUF_AW'(x_p1)) : '0;
  assign buf_data = (vld_p1 && !black_l) ? rom_data : '0;
  assign buf_we   = vld_p1 & in_p1 & pixel_written(black_l, rom_data);

  assign finished = (state_q == ST_DONE);
  assign busy     = (state_q == ST_RUN) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized scoreboard bench for sprite_blitter: a behavioural model predicts
// every frame-buffer write and the finished cycle; a monitor checks them.
module tb_sprite_blitter;

  localparam int SW = 160;
  localparam int SH = 120;

  logic        clock = 1'b0;
  logic        reset;
  logic        draw_req;
  logic [3:0]  sprite_id;
  logic [7:0]  origin_x;
  logic [6:0]  origin_y;
  logic        black;
  logic [11:0] rom_addr;
  logic [2:0]  rom_data;
  logic [14:0] buf_addr;
  logic [2:0]  buf_data;
  logic        buf_we;
  logic        finished;
  logic        busy;

  sprite_blitter dut (
    .clock     (clock),
    .reset     (reset),
    .draw_req  (draw_req),
    .sprite_id (sprite_id),
    .origin_x  (origin_x),
    .origin_y  (origin_y),
    .black     (black),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .buf_we    (buf_we),
    .finished  (finished),
    .busy      (busy)
  );

  always #10 clock = ~clock;

  logic [2:0] rom [4096];
  always @(posedge clock) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  fin_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  int  first_addr = -1;
  int  last_addr = -1;
  int  last_fin = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin : monitor
    wr_t e;
    if (!reset) begin
      if (buf_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d, expected no write", buf_addr, buf_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(buf_addr), int'(e.addr));
          chk("wr_data", int'(buf_data), int'(e.data));
        end
        if (wr_cnt == 0) first_addr = int'(buf_addr);
        last_addr = int'(buf_addr);
        wr_cnt++;
      end
      if (finished) begin
        last_fin = cyc;
        if (fin_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_finished: seen at cycle %0d, expected none", cyc);
        end else begin
          chk("finished_cycle", cyc, fin_q.pop_front());
        end
        chk("busy_with_finished", int'(busy), 0);
      end
    end
  end

  // Reference: every pixel of the sprite rectangle, in raster order, clipped.
  task automatic model(input int id, input int ox, input int oy, input bit blk, output int n);
    int x, y;
    logic [2:0] c;
    wr_t w;
    n = 0;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 16; k++) begin
        x = ox + k;
        y = oy + r;
        c = rom[id * 256 + r * 16 + k];
        if (x < SW && y < SH && (blk || c != 3'b101)) begin
          w.addr = 15'(y * SW + x);
          w.data = blk ? 3'b000 : c;
          exp_q.push_back(w);
          n++;
        end
      end
    end
  endtask

  // sample_delay: edges from now until the request is sampled in IDLE.
  task automatic start_draw(input int id, input int ox, input int oy, input bit blk,
                            input bit sync, input int sample_delay, output int n);
    if (sync) @(negedge clock);
    sprite_id = 4'(id);
    origin_x  = 8'(ox);
    origin_y  = 7'(oy);
    black     = blk;
    draw_req  = 1'b1;
    wr_cnt    = 0;
    model(id, ox, oy, blk, n);
    fin_q.push_back(cyc + sample_delay + 257);
  endtask

  task automatic wait_finish(input bit drop);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 700 && !seen; i++) begin
      @(negedge clock);
      if (finished) begin
        seen = 1'b1;
        if (drop) draw_req = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL finish_timeout: no finished within 700 cycles, expected one");
    end
  endtask

  task automatic end_check(input string name, input int exp_cnt);
    chk(name, wr_cnt, exp_cnt);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n, fin_a;
    reset = 1'b1;
    draw_req = 1'b0;
    sprite_id = '0;
    origin_x = '0;
    origin_y = '0;
    black = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 3'($urandom_range(0, 7));
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 16; k++) begin
        rom[2 * 256 + r * 16 + k] = ((k % 8) == 5) ? 3'b100 : 3'(k % 8);
        rom[9 * 256 + r * 16 + k] = (k % 2 == 0) ? 3'b101 : 3'b010;
      end
    end

    repeat (3) @(negedge clock);
    chk("rst_buf_we", int'(buf_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finished", int'(finished), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_buf_addr", int'(buf_addr), 0);
    chk("rst_buf_data", int'(buf_data), 0);
    reset = 1'b0;

    // Opaque sprite 2 fully on screen
    start_draw(2, 16, 32, 1'b0, 1'b1, 1, n);
    wait_finish(1'b1);
    end_check("cnt_opaque", 256);
    chk("first_addr", first_addr, 5136);
    chk("last_addr", last_addr, (32 + 15) * SW + (16 + 15));

    // Transparent every even column, then the same sprite forced black
    start_draw(9, 40, 40, 1'b0, 1'b1, 1, n);
    wait_finish(1'b1);
    end_check("cnt_transparent", 128);
    start_draw(9, 40, 40, 1'b1, 1'b1, 1, n);
    wait_finish(1'b1);
    end_check("cnt_black", 256);

    // Bottom-right clipping
    start_draw(2, 152, 112, 1'b0, 1'b1, 1, n);
    wait_finish(1'b1);
    end_check("cnt_clipped", 64);
    chk("clip_last_addr", last_addr, 119 * SW + 159);

    // Inputs changed mid-draw are ignored
    start_draw(2, 8, 8, 1'b0, 1'b1, 1, n);
    repeat (50) @(negedge clock);
    draw_req = 1'b0;
    origin_x = 8'd100;
    black = 1'b1;
    wait_finish(1'b1);
    end_check("cnt_atomic", 256);

    // Reset mid-draw aborts without a finished pulse
    start_draw(3, 20, 20, 1'b0, 1'b1, 1, n);
    repeat (100) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_buf_we", int'(buf_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_finished", int'(finished), 0);
    exp_q.delete();
    fin_q.delete();
    draw_req = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    start_draw(2, 0, 0, 1'b0, 1'b1, 1, n);
    wait_finish(1'b1);
    end_check("cnt_after_reset", 256);
    chk("first_after_reset", first_addr, 0);

    // Back-to-back: B raised while A's finished is still high
    start_draw(2, 64, 64, 1'b0, 1'b1, 1, n);
    wait_finish(1'b0);
    fin_a = last_fin;
    end_check("cnt_b2b_a", n);
    start_draw(7, 100, 50, 1'b0, 1'b0, 2, n);
    wait_finish(1'b1);
    end_check("cnt_b2b_b", n);
    chk("b2b_gap", last_fin - fin_a, 259);

    // Randomized draws
    for (int t = 0; t < 5; t++) begin
      start_draw(int'($urandom_range(0, 15)), int'($urandom_range(0, 200)),
                 int'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0), 1'b1, 1, n);
      wait_finish(1'b1);
      end_check("cnt_random", n);
    end

    repeat (5) @(negedge clock);
    chk("no_stray_finished", fin_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
